ysyx_25020047_dmem_ctrl: RTL and testbench
==========================================

# ysyx_25020047_dmem_ctrl

Multi-cycle data-memory controller that sits directly downstream of the LSU. It replaces the LSU's combinational DPI memory calls with a valid/ready request/response handshake. It performs byte-lane alignment for stores and lane extraction with sign or zero extension for loads. It drives a single-port synchronous memory with a configurable injected access latency, so the core can be exercised against non-ideal memory timing.

## Interface
Parameters:
- LATENCY, 2: extra idle cycles inserted between request accept and memory access (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  controller can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  LSU accepts response.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  misaligned access, or illegal funct3 (011, 110, 111; also 100/101 on stores).
- mem_en  out  1  memory access strobe, exactly one cycle per legal request.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  32  word-aligned address ({req_addr[31:2], 2'b00}).
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte-lane write mask.
- mem_rdata  in  32  read word, valid in the cycle after mem_en.

## Operation
- States: IDLE, WAIT, ACCESS, CAPT, RESP. Reset state is IDLE.
- IDLE
  - req_ready = 1. On req_valid && req_ready, latch wen, funct3, addr, wdata.
  - Illegal or misaligned request (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1, rdata=0. No memory access.
  - Otherwise -> WAIT with counter=LATENCY, or -> ACCESS directly if LATENCY=0.
- WAIT: decrement counter each cycle; at counter==1 -> ACCESS.
- ACCESS: mem_en=1 for one cycle; mem_we=wen.
  - Store lane shift: wdata << (8*addr[1:0]).
  - Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - Loads: mem_wmask=0.
  - Next state CAPT.
- CAPT
  - Loads: select lane mem_rdata >> (8*addr[1:0]). Extend bit 7 (b) or bit 15 (h); zero-extend for bu/hu; pass w unchanged. Register the result into rsp_rdata.
  - Stores: rsp_rdata=0.
  - Next state RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable while rsp_ready=0. On rsp_ready -> IDLE; clear rsp_valid, rsp_err, rsp_rdata.
- req_ready=0 in every state except IDLE; no request overlap; one outstanding transaction.
- mem_* outputs are 0 whenever mem_en=0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- Legal request accepted at edge N:
  - mem_en high in cycle N+LATENCY+1.
  - rsp_valid high from cycle N+LATENCY+3.
- Error request accepted at edge N: rsp_valid high in cycle N+1.
- Response handshake at edge M: req_ready=1 in cycle M+1. Earliest next accept at edge M+1, so there is no back-to-back accept in the response cycle.
- rsp_ready held high before rsp_valid: response is consumed in its first valid cycle.
- Asynchronous reset mid-transaction (any state): immediately return to IDLE with reset output values. A pending mem_en is dropped; the transaction is lost and produces no response.
- req_valid deasserted before acceptance: no effect. Inputs other than req_* are ignored outside IDLE.

## Test plan
- Reset: assert rst_n=0 mid-WAIT -> outputs take reset values the same cycle; after release, req_ready=1 and no rsp_valid.
- Word load, LATENCY=2: addr 0x80000004, mem_rdata 0xDEADBEEF.
  - Accept at edge 0 -> mem_en in cycle 3 with mem_addr 0x80000004.
  - rsp_valid at cycle 5 with rsp_rdata 0xDEADBEEF.
- Byte loads: addr 0x80000003, mem_rdata 0x80112233.
  - lb -> 0xFFFFFF80.
  - lbu -> 0x00000080.
  - lhu at 0x80000002 -> 0x00008011.
  - lh at 0x80000002 -> 0xFFFF8011.
- Stores:
  - sb 0x000000AB at addr ...01 -> mem_wdata 0x0000AB00, mem_wmask 4'b0010, mem_we=1.
  - sh 0x1234 at addr ...02 -> mem_wdata 0x12340000, mask 4'b1100.
  - rsp_rdata=0 for both.
- Misaligned: lw at 0x80000002 -> no mem_en, rsp_valid cycle 1, rsp_err=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 and a second req_valid is not accepted. Release -> IDLE next cycle; second request accepted.

Source files
------------

// File: rtl/ysyx_25020047_dmem_ctrl_if.sv
// rtl/ysyx_25020047_dmem_ctrl_if.sv - LSU request/response and memory port bundle for the data memory controller
interface ysyx_25020047_dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_25020047_dmem_ctrl.sv
// rtl/ysyx_25020047_dmem_ctrl.sv - LSU-facing data memory controller with injected access latency
module ysyx_25020047_dmem_ctrl #(
    parameter int unsigned LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ysyx_25020047_dmem_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_ok;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [3:0]  store_mask;

    // Legality is judged on the live request so an illegal one never enters the memory path.
    always_comb begin
        req_ok = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_ok = 1'b1;
            3'b001:  req_ok = ~bus.req_addr[0];
            3'b010:  req_ok = (bus.req_addr[1:0] == 2'b00);
            3'b100:  req_ok = ~bus.req_wen;
            3'b101:  req_ok = ~bus.req_wen & ~bus.req_addr[0];
            default: req_ok = 1'b0;
        endcase
    end

    assign lane = bus.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = lane;
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   store_mask = 4'b0001 << addr_q[1:0];
            2'b01:   store_mask = 4'b0011 << addr_q[1:0];
            default: store_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!req_ok) begin
                        state_nx = RESP;
                    end else if (LAT == 4'd0) begin
                        state_nx = ACCESS;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = CAPT;
            CAPT:    state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory-side outputs are forced to zero outside the single ACCESS cycle.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wmask = 4'd0;
        if (state == ACCESS) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = wen_q;
            bus.mem_addr = {addr_q[31:2], 2'b00};
            if (wen_q) begin
                bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
                bus.mem_wmask = store_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req_valid) begin
                wen_q    <= bus.req_wen;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                rdata_q  <= 32'd0;
                err_q    <= ~req_ok;
            end
            if (state == CAPT) begin
                rdata_q <= wen_q ? 32'd0 : load_val;
            end
            if (state == RESP && bus.rsp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_dmem_ctrl.sv
// tb/tb_ysyx_25020047_dmem_ctrl.sv - randomized self-checking bench with a byte-level memory reference model
module tb_ysyx_25020047_dmem_ctrl;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_25020047_dmem_ctrl_if bus();

    ysyx_25020047_dmem_ctrl #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // dev_mem is the memory the DUT writes through its mem_* port; ref_mem follows the ISA rules.
    bit [31:0] dev_mem [32];
    bit [31:0] ref_mem [32];

    bit [31:0] got_rdata, got_wdata;
    bit [3:0]  got_mask;
    bit        got_err, got_we;

    function automatic bit [31:0] load_ext(input bit [31:0] word, input bit [2:0] f3, input int off);
        bit [31:0] s, b, h;
        s = word >> (8 * off);
        b = s % 256;
        h = s % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic bit [31:0] byte_mask(input bit [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic run_txn(input bit wen, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                           input int hold, input bit keep_valid, input bit sync);
        int        size, off, cyc, mem_cyc, n_mem, n_valid, exp_cyc;
        bit [4:0]  idx;
        bit        legal, hs, done;
        bit [31:0] exp_rdata, exp_wdata, rword, w;
        bit [3:0]  exp_mask;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        idx   = addr[6:2];
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!wen && (f3 == 3'd4 || f3 == 3'd5)))
                && (off % size == 0);
        exp_cyc   = legal ? LAT + 3 : 1;
        exp_wdata = wdata << (8 * off);
        exp_mask  = 4'd0;
        exp_rdata = 32'd0;
        if (legal) begin
            for (int i = 0; i < size; i++) exp_mask = exp_mask | 4'(1 << (off + i));
            if (wen) begin
                w = ref_mem[idx];
                for (int i = 0; i < size; i++)
                    w = (w & ~(32'hFF << (8 * (off + i)))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * (off + i)));
                ref_mem[idx] = w;
            end else begin
                exp_rdata = load_ext(ref_mem[idx], f3, off);
            end
        end
        got_rdata = 32'd0; got_wdata = 32'd0; got_mask = 4'd0; got_err = 1'b0; got_we = 1'b0;

        if (sync) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.rsp_ready  = (hold == 0);
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
        end
        cyc = 0; mem_cyc = -10; n_mem = 0; n_valid = 0; hs = 1'b0; done = 1'b0; rword = 32'd0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!keep_valid) bus.req_valid = 1'b0;
            if (hs) begin
                tests++;
                if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
                    fails++;
                    $display("FAIL rsp_release: valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                             bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
                end
                done = 1'b1;
            end else begin
                if (bus.mem_en === 1'b1) begin
                    n_mem++;
                    mem_cyc   = cyc;
                    got_we    = bus.mem_we;
                    got_wdata = bus.mem_wdata;
                    got_mask  = bus.mem_wmask;
                    tests++;
                    if (cyc != LAT + 1 || bus.mem_addr !== {addr[31:2], 2'b00} || bus.mem_we !== wen
                        || bus.mem_wmask !== (wen ? exp_mask : 4'd0) || (wen && bus.mem_wdata !== exp_wdata)) begin
                        fails++;
                        $display("FAIL mem_access: cyc=%0d addr=%h we=%b wdata=%h mask=%b want cyc=%0d addr=%h we=%b wdata=%h mask=%b",
                                 cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wmask,
                                 LAT + 1, {addr[31:2], 2'b00}, wen, exp_wdata, wen ? exp_mask : 4'd0);
                    end
                    if (bus.mem_we)
                        dev_mem[bus.mem_addr[6:2]] = (dev_mem[bus.mem_addr[6:2]] & ~byte_mask(bus.mem_wmask))
                                                     | (bus.mem_wdata & byte_mask(bus.mem_wmask));
                    rword = dev_mem[bus.mem_addr[6:2]];
                end else begin
                    tests++;
                    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_wmask !== 4'd0) begin
                        fails++;
                        $display("FAIL mem_idle_zero: we=%b addr=%h wdata=%h mask=%b want all 0",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
                    end
                end
                bus.mem_rdata = (cyc == mem_cyc + 1) ? rword : $urandom;
                if (bus.rsp_valid === 1'b1) begin
                    n_valid++;
                    tests++;
                    if ((n_valid == 1 && cyc != exp_cyc) || bus.rsp_rdata !== exp_rdata
                        || bus.rsp_err !== (legal ? 1'b0 : 1'b1) || bus.req_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL rsp: cyc=%0d rdata=%h err=%b req_ready=%b want cyc=%0d rdata=%h err=%b req_ready=0",
                                 cyc, bus.rsp_rdata, bus.rsp_err, bus.req_ready, exp_cyc, exp_rdata, !legal);
                    end
                    got_rdata = bus.rsp_rdata;
                    got_err   = bus.rsp_err;
                    if (n_valid == hold + 1) begin
                        bus.rsp_ready = 1'b1;
                        hs = 1'b1;
                    end
                end else begin
                    tests++;
                    if (bus.req_ready !== 1'b0 || n_valid > 0) begin
                        fails++;
                        $display("FAIL busy: req_ready=%b rsp_dropped=%0d want 0 0", bus.req_ready, n_valid);
                    end
                end
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL txn_timeout: got no completed response within 64 cycles, want completion");
        end
        tests++;
        if (n_mem != (legal ? 1 : 0)) begin
            fails++;
            $display("FAIL mem_en_count: got %0d want %0d", n_mem, legal ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        tests++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_wmask !== 4'd0) begin
            fails++;
            $display("FAIL reset_mem: en=%b we=%b addr=%h wdata=%h mask=%b want all 0",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid(input int at_cyc);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h80000010; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (at_cyc - 1) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_%0d: ready=%b valid=%b mem_en=%b mem_addr=%h want 1 0 0 0",
                     at_cyc, bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_mid_quiet: mem_en=%b valid=%b ready=%b want 0 0 1",
                         bus.mem_en, bus.rsp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_word_load;
        dev_mem[1] = 32'hDEADBEEF;
        ref_mem[1] = 32'hDEADBEEF;
        run_txn(1'b0, 3'b010, 32'h80000004, 32'd0, 0, 1'b0, 1'b1);
        tests++;
        if (got_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL word_load: got %h want deadbeef", got_rdata);
        end
    endtask

    task automatic test_byte_loads;
        bit [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        bit [31:0] adrs [4] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002};
        bit [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011};
        dev_mem[0] = 32'h80112233;
        ref_mem[0] = 32'h80112233;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, f3s[i], adrs[i], 32'd0, 0, 1'b0, 1'b1);
            tests++;
            if (got_rdata !== exps[i]) begin
                fails++;
                $display("FAIL byte_load_%0d: got %h want %h", i, got_rdata, exps[i]);
            end
        end
    endtask

    task automatic test_stores;
        run_txn(1'b1, 3'b000, 32'h80000041, 32'h000000AB, 0, 1'b0, 1'b1);
        tests++;
        if (got_wdata !== 32'h0000AB00 || got_mask !== 4'b0010 || got_we !== 1'b1 || got_rdata !== 32'd0) begin
            fails++;
            $display("FAIL store_sb: wdata=%h mask=%b we=%b rdata=%h want 0000ab00 0010 1 0",
                     got_wdata, got_mask, got_we, got_rdata);
        end
        run_txn(1'b1, 3'b001, 32'h80000042, 32'h00001234, 1, 1'b0, 1'b1);
        tests++;
        if (got_wdata !== 32'h12340000 || got_mask !== 4'b1100 || got_we !== 1'b1 || got_rdata !== 32'd0) begin
            fails++;
            $display("FAIL store_sh: wdata=%h mask=%b we=%b rdata=%h want 12340000 1100 1 0",
                     got_wdata, got_mask, got_we, got_rdata);
        end
    endtask

    task automatic test_misaligned;
        run_txn(1'b0, 3'b010, 32'h80000002, 32'd0, 0, 1'b0, 1'b1);
        tests++;
        if (got_err !== 1'b1 || got_rdata !== 32'd0) begin
            fails++;
            $display("FAIL misaligned_lw: err=%b rdata=%h want 1 0", got_err, got_rdata);
        end
        run_txn(1'b1, 3'b100, 32'h80000000, 32'h55, 2, 1'b0, 1'b1);
        tests++;
        if (got_err !== 1'b1) begin
            fails++;
            $display("FAIL store_bu_illegal: err=%b want 1", got_err);
        end
    endtask

    task automatic test_backpressure;
        bit [31:0] d;
        d = $urandom;
        run_txn(1'b0, 3'b010, 32'h80000008, 32'd0, 5, 1'b1, 1'b1);
        run_txn(1'b1, 3'b010, 32'h8000000C, d, 0, 1'b0, 1'b0);
        run_txn(1'b0, 3'b010, 32'h8000000C, 32'd0, 0, 1'b0, 1'b1);
        tests++;
        if (got_rdata !== d) begin
            fails++;
            $display("FAIL backpressure_readback: got %h want %h", got_rdata, d);
        end
    endtask

    task automatic test_random;
        bit [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bit        wen;
        bit [2:0]  f3;
        bit [31:0] addr;
        for (int n = 0; n < 80; n++) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
            addr = 32'h80000000 | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0)
                addr = addr & ((f3[1:0] == 2'b00) ? 32'hFFFFFFFF : (f3[1:0] == 2'b01) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
            run_txn(wen, f3, addr, $urandom, $urandom_range(0, 3), 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        bus.mem_rdata  = 32'd0;
        for (int i = 0; i < 32; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        test_reset();
        test_word_load();
        test_byte_loads();
        test_stores();
        test_misaligned();
        test_backpressure();
        test_reset_mid(2);
        test_reset_mid(LAT + 1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
